// File: rtl/psum_deskew_collector.sv
// -----------------------------------------------------------------------------
// psum_deskew_collector
//
// Purpose:
//   Collects the bottom-row partial sums of a weight-stationary PE array.
//   Column c of output vector t leaves the array c qualified cycles after
//   column 0. Each lane is delayed by NUM_COLS-1-c qualified cycles so that
//   all lanes of one vector line up. Aligned vectors go into a small
//   first-word-fall-through FIFO that feeds a downstream writer over
//   valid/ready. stall tells the array controller to freeze the array.
//
// Ports:
//   CLK       in   clock
//   RESET     in   synchronous active-low reset
//   start     in   one-cycle pulse starting a tile (honoured only in IDLE)
//   tile_len  in   number of output vectors M in the tile, sampled on start
//   in_valid  in   array advanced this cycle; qualifies in_sum
//   in_sum    in   bottom-row psums, lane c = bits [c*PSUM_W +: PSUM_W]
//   stall     out  FIFO full; the array must hold in_valid low
//   out_vec   out  aligned vector at the FIFO head (0 when empty)
//   out_valid out  out_vec holds a vector
//   out_ready in   downstream accepts; pop on out_valid & out_ready
//   out_last  out  head vector is vector M-1 of the tile
//   busy      out  state is not IDLE
//   done      out  one-cycle pulse when the tile has fully drained
//   overflow  out  sticky: a push was dropped; cleared by reset or start
// -----------------------------------------------------------------------------
module psum_deskew_collector #(
    parameter int NUM_COLS   = 16,
    parameter int PSUM_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       start,
    input  logic [LEN_W-1:0]           tile_len,
    input  logic                       in_valid,
    input  logic [NUM_COLS*PSUM_W-1:0] in_sum,
    output logic                       stall,
    output logic [NUM_COLS*PSUM_W-1:0] out_vec,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow
);

    localparam int VEC_W = NUM_COLS * PSUM_W;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    // k runs up to M+NUM_COLS-2, so it needs room beyond LEN_W.
    localparam int K_W   = LEN_W + $clog2(NUM_COLS) + 1;
    localparam logic [K_W-1:0] SKEW = K_W'(NUM_COLS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t             state_q;
    logic [LEN_W-1:0]   m_q;
    logic [K_W-1:0]     k_q;
    logic               done_q;
    logic               overflow_q;

    logic [VEC_W-1:0]   mem_q [FIFO_DEPTH];
    logic [LEN_W-1:0]   tag_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;

    logic               qual;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic               wr_en;
    logic               drop;
    logic [K_W-1:0]     m_ext;
    logic [K_W-1:0]     t_full;
    logic [K_W-1:0]     last_k;
    logic [VEC_W-1:0]   aligned;

    // ------------------------------------------------------------------
    // Qualification and push window
    // ------------------------------------------------------------------
    assign qual   = in_valid && (state_q == S_COLLECT);
    assign m_ext  = {{(K_W-LEN_W){1'b0}}, m_q};
    assign t_full = k_q - SKEW;
    // Only words whose vector index t = k-(NUM_COLS-1) lies in [0, M) are real.
    assign push   = qual && (k_q >= SKEW) && (t_full < m_ext);
    assign last_k = m_ext + SKEW - K_W'(1);

    // ------------------------------------------------------------------
    // Per-lane deskew chains; lane c has NUM_COLS-1-c stages and only
    // advances on qualified cycles so array freezes keep lanes aligned.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_COLS; gi++) begin : g_lane
            localparam int DEPTH = NUM_COLS - 1 - gi;
            if (DEPTH == 0) begin : g_direct
                assign aligned[gi*PSUM_W +: PSUM_W] = in_sum[gi*PSUM_W +: PSUM_W];
            end else begin : g_chain
                logic [PSUM_W-1:0] sr_q [DEPTH];
                always_ff @(posedge CLK) begin
                    if (!RESET) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            sr_q[i] <= '0;
                        end
                    end else if (qual) begin
                        sr_q[0] <= in_sum[gi*PSUM_W +: PSUM_W];
                        for (int i = 1; i < DEPTH; i++) begin
                            sr_q[i] <= sr_q[i-1];
                        end
                    end
                end
                assign aligned[gi*PSUM_W +: PSUM_W] = sr_q[DEPTH-1];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // FWFT FIFO. A push while full is still accepted when a pop frees the
    // head slot in the same cycle (wr_ptr == rd_ptr then).
    // ------------------------------------------------------------------
    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign pop     = !empty && out_ready;
    assign wr_en   = push && (!full || pop);
    assign drop    = push && full && !pop;
    assign count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage is data-only (no reset); the output is masked while empty.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= aligned;
            tag_q[wr_ptr_q] <= t_full[LEN_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Tile control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            m_q        <= '0;
            k_q        <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (drop) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        overflow_q <= 1'b0;
                        if (tile_len != '0) begin
                            m_q     <= tile_len;
                            k_q     <= '0;
                            state_q <= S_COLLECT;
                        end else begin
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    if (qual) begin
                        k_q <= k_q + K_W'(1);
                        if (k_q == last_k) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // No pushes happen here, so an empty FIFO means the
                    // tile is fully delivered and out_valid is already low.
                    if (empty) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all derived from registered state)
    // ------------------------------------------------------------------
    assign stall     = full;
    assign out_valid = !empty;
    assign out_vec   = empty ? '0 : mem_q[rd_ptr_q];
    assign out_last  = !empty && (tag_q[rd_ptr_q] == (m_q - LEN_W'(1)));
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_psum_deskew_collector.sv
// -----------------------------------------------------------------------------
// tb_psum_deskew_collector
//
// Drives skewed psum tiles into psum_deskew_collector (4 columns, 4-deep FIFO).
// Lane c at qualified cycle k carries 100*(k-c)+c, or 0xDEAD outside the tile.
// Expected aligned vectors {100t+c} are queued when a tile is issued; a monitor
// forked alongside the stimulus pops and compares on every accepted output.
// -----------------------------------------------------------------------------
module tb_psum_deskew_collector;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int D  = 4;
    localparam int LW = 16;
    localparam int VW = N * W;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          start;
    logic [LW-1:0] tile_len;
    logic          in_valid;
    logic [VW-1:0] in_sum;
    logic          stall;
    logic [VW-1:0] out_vec;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          overflow;

    psum_deskew_collector #(
        .NUM_COLS   (N),
        .PSUM_W     (W),
        .FIFO_DEPTH (D),
        .LEN_W      (LW)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .start     (start),
        .tile_len  (tile_len),
        .in_valid  (in_valid),
        .in_sum    (in_sum),
        .stall     (stall),
        .out_vec   (out_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // out_ready: 0 = low, 1 = high, 2 = random each cycle
    int ready_mode = 0;
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    typedef struct {
        logic [VW-1:0] vec;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    int   n_pops   = 0;
    int   drv_pushes = 0;
    int   q3_cyc = -1;
    int   first_valid_cyc = -1;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference: vector t of a tile of length m is lane c = 100*t + c.
    task automatic push_expected(input int m, input int limit);
        for (int t = 0; t < m && t < limit; t++) begin
            exp_t e;
            for (int c = 0; c < N; c++) begin
                e.vec[c*W +: W] = W'(100 * t + c);
            end
            e.last = (t == m - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge CLK);
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready) begin
                n_pops++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pop: got vec %h expected no output", out_vec);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("pop %0d @%0d: vec=%h last=%0b", n_pops, cyc, out_vec, out_last);
                    check("out_vec", out_vec, e.vec);
                    check("out_last", VW'(out_last), VW'(e.last));
                end
            end
            if (done) begin
                done_cnt++;
                check("done_without_valid", VW'(out_valid), '0);
            end
        end
    endtask

    // Issue one tile: m vectors, gap_mode 0=constant 1=toggle 2=random.
    task automatic run_tile(input int m, input int gap_mode, input bit respect_stall,
                            input int abort_pushes, input bit spur);
        int k;
        int iter;
        bit want;
        bit tog;
        logic [VW-1:0] sum;
        tick();
        start    = 1'b1;
        tile_len = LW'(m);
        tick();
        start = 1'b0;
        k = 0; iter = 0; tog = 1'b0; drv_pushes = 0;
        while (k < m + N - 1) begin
            case (gap_mode)
                0:       want = 1'b1;
                1:       want = !tog;
                default: want = ($urandom_range(0, 2) != 0);
            endcase
            tog = !tog;
            if (respect_stall && stall) want = 1'b0;
            if (spur && iter == 3) begin
                start    = 1'b1;
                tile_len = LW'(2);
            end else begin
                start = 1'b0;
            end
            for (int c = 0; c < N; c++) begin
                int v;
                v = k - c;
                sum[c*W +: W] = (v >= 0 && v < m) ? W'(100 * v + c) : W'(32'hDEAD);
            end
            if (!want) sum = {$urandom(), $urandom(), $urandom(), $urandom()};
            in_valid = want;
            in_sum   = sum;
            if (want) begin
                if (k == N - 1) q3_cyc = cyc;
                if (k >= N - 1) drv_pushes++;
                k++;
            end
            tick();
            iter++;
            if (abort_pushes > 0 && drv_pushes >= abort_pushes) break;
            if (iter > 3000) begin
                n_checks++;
                n_fail++;
                $display("FAIL driver_timeout: got k=%0d expected %0d", k, m + N - 1);
                break;
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int i;
        d0 = done_cnt;
        for (i = 0; i < budget; i++) begin
            if (done_cnt > d0) break;
            tick();
        end
        check("done_seen", VW'(done_cnt > d0), VW'(1));
        repeat (3) tick();
        check("done_once", VW'(done_cnt - d0), VW'(1));
        check("queue_drained", VW'(exp_q.size()), '0);
    endtask

    initial begin
        int m;
        int d0;
        int i;
        RESET = 1'b0; start = 1'b0; tile_len = '0; in_valid = 1'b0; in_sum = '0;
        fork
            monitor();
        join_none

        // ---------------- reset state ----------------
        repeat (3) tick();
        check("rst_out_valid", VW'(out_valid), '0);
        check("rst_out_last",  VW'(out_last),  '0);
        check("rst_stall",     VW'(stall),     '0);
        check("rst_busy",      VW'(busy),      '0);
        check("rst_done",      VW'(done),      '0);
        check("rst_overflow",  VW'(overflow),  '0);
        check("rst_out_vec",   out_vec,        '0);
        RESET = 1'b1;

        // ---------------- basic alignment ----------------
        ready_mode = 1;
        first_valid_cyc = -1;
        push_expected(3, 3);
        run_tile(3, 0, 1'b1, 0, 1'b0);
        wait_done(100);
        check("first_valid_latency", VW'(first_valid_cyc - q3_cyc), VW'(1));

        // ---------------- gapped input ----------------
        push_expected(3, 3);
        run_tile(3, 1, 1'b1, 0, 1'b0);
        wait_done(100);

        // ---------------- backpressure ----------------
        ready_mode = 0;
        push_expected(8, 8);
        fork
            run_tile(8, 0, 1'b1, 0, 1'b0);
            begin
                for (i = 0; i < 200; i++) begin
                    @(negedge CLK);
                    if (stall) break;
                end
                check("stall_rose", VW'(stall), VW'(1));
                check("pushes_at_stall", VW'(drv_pushes), VW'(D));
                repeat (5) @(negedge CLK);
                check("bp_overflow", VW'(overflow), '0);
                check("bp_stall_held", VW'(stall), VW'(1));
                ready_mode = 1;
                @(negedge CLK);
                @(negedge CLK);
                check("stall_fell", VW'(stall), '0);
            end
        join
        wait_done(200);

        // ---------------- overflow ----------------
        ready_mode = 0;
        push_expected(8, D);
        run_tile(8, 0, 1'b0, 0, 1'b0);
        repeat (2) tick();
        check("ovf_set", VW'(overflow), VW'(1));
        check("ovf_stall", VW'(stall), VW'(1));
        check("ovf_busy", VW'(busy), VW'(1));
        ready_mode = 1;
        wait_done(100);
        check("ovf_sticky", VW'(overflow), VW'(1));

        // ---------------- zero-length tile ----------------
        tick();
        start = 1'b1;
        tile_len = '0;
        tick();
        start = 1'b0;
        check("zero_done", VW'(done), VW'(1));
        check("zero_busy", VW'(busy), '0);
        check("zero_valid", VW'(out_valid), '0);
        check("ovf_cleared_by_start", VW'(overflow), '0);
        tick();
        check("zero_done_pulse", VW'(done), '0);

        // ---------------- start during COLLECT ----------------
        push_expected(5, 5);
        run_tile(5, 2, 1'b1, 0, 1'b1);
        wait_done(200);

        // ---------------- reset mid-tile ----------------
        ready_mode = 0;
        tick();
        run_tile(8, 0, 1'b1, 2, 1'b0);
        d0 = done_cnt;
        RESET = 1'b0;
        tick();
        check("midrst_out_valid", VW'(out_valid), '0);
        check("midrst_busy",      VW'(busy),      '0);
        check("midrst_stall",     VW'(stall),     '0);
        check("midrst_done",      VW'(done),      '0);
        RESET = 1'b1;
        repeat (3) tick();
        check("midrst_no_done", VW'(done_cnt - d0), '0);
        ready_mode = 1;
        push_expected(1, 1);
        run_tile(1, 0, 1'b1, 0, 1'b0);
        wait_done(100);

        // ---------------- randomized tiles ----------------
        ready_mode = 2;
        repeat (6) begin
            m = $urandom_range(1, 10);
            push_expected(m, m);
            run_tile(m, 2, 1'b1, 0, 1'b0);
            wait_done(600);
        end
        ready_mode = 1;
        repeat (3) tick();
        check("final_overflow", VW'(overflow), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/psum_deskew_collector.md
Name: psum_deskew_collector

Overview:
- Sits at the bottom edge of the weight-stationary PE array and consumes the final-row partial sums.
- The array emits column c of output vector t c qualified cycles after column 0. This block delays each column by its skew so every column of a vector lines up again.
- It buffers the aligned vectors in a small FWFT FIFO and hands them to the downstream writer over a valid/ready handshake.
- It raises stall so the array controller can freeze the array when the buffer cannot accept data.

Parameters:
- NUM_COLS, 16, number of array columns / psum lanes
- PSUM_W, 32, width of one psum lane
- FIFO_DEPTH, 4, aligned-vector buffer depth (power of 2, >=2)
- LEN_W, 16, width of the tile-length field

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse that begins a tile; honoured only in IDLE
- tile_len  in  LEN_W  number of output vectors M in the tile; sampled on start
- in_valid  in  1  array advanced this cycle (array EN); qualifies in_sum
- in_sum  in  NUM_COLS*PSUM_W  bottom-row psums; lane c = bits [c*PSUM_W +: PSUM_W]
- stall  out  1  FIFO full; the array controller must hold in_valid low
- out_vec  out  NUM_COLS*PSUM_W  aligned vector at the FIFO head, same lane order
- out_valid  out  1  out_vec holds a vector
- out_ready  in  1  downstream accepts; a pop happens when out_valid & out_ready
- out_last  out  1  head vector is vector M-1 of the tile
- busy  out  1  high whenever the state is not IDLE
- done  out  1  one-cycle pulse when the tile is fully drained
- overflow  out  1  sticky: a push was dropped; cleared by reset or start

Behaviour:
- Reset (RESET=0 at a clock edge):
  - state=IDLE; FIFO empty; counters and delay lines zeroed.
  - out_valid=0, out_last=0, stall=0, busy=0, done=0, overflow=0, out_vec=0.
  - Reset mid-tile abandons the tile; no done pulse is produced.
- Qualified cycle = a cycle with in_valid=1 in state COLLECT. Counter k counts qualified cycles from 0. In_valid outside COLLECT is ignored.
- Deskew:
  - Lane c passes through a shift chain of NUM_COLS-1-c stages. The chain advances only on qualified cycles; lane NUM_COLS-1 has zero delay.
  - At qualified cycle k, the aligned word is vector t=k-(NUM_COLS-1).
  - It is pushed into the FIFO when 0<=t<M, at the clock edge ending that cycle.
- Timing:
  - out_valid rises the cycle after the push (FWFT).
  - Pipeline latency = NUM_COLS-1 qualified cycles plus 1 clock.
- FIFO:
  - stall = (count==FIFO_DEPTH), registered-state-derived with no combinational path from out_ready.
  - Push and pop in the same cycle are both performed, including when full.
  - Push when full with no pop drops the vector and sets overflow; the counters still advance.
- out_last = head entry's tag (stored per entry) equal to M-1.
- FSM:
  - IDLE: on start with tile_len>0, latch M, clear k and overflow, go to COLLECT. On start with tile_len=0, pulse done next cycle and stay IDLE. Start while busy is ignored.
  - COLLECT: go to DRAIN on the qualified cycle with k = M+NUM_COLS-2, the last push.
  - DRAIN: go to IDLE when the FIFO is empty, pulsing done for one cycle on entry to IDLE. done is never asserted together with out_valid.
- Arithmetic: pure data movement; no lane is modified or sign-extended.

Test Plan:
- Setup: NUM_COLS=4, FIFO_DEPTH=4. Lane c at qualified cycle k drives 100*(k-c)+c, or 0xDEAD when k-c is out of range.
- Basic alignment: start with M=3, in_valid constant, out_ready=1.
  - Expect out_vec lanes {100t+0, 100t+1, 100t+2, 100t+3} for t=0,1,2.
  - The first out_valid appears 1 clock after qualified cycle 3.
  - out_last is high only on t=2; no 0xDEAD is ever output; done pulses once after the last pop.
- Gapped input: same stimulus with in_valid toggling 1,0,1,0.
  - Expect identical output vectors; the chains hold during gaps.
- Backpressure: M=8, out_ready=0.
  - stall rises after 4 pushes; the bench holds in_valid low and overflow stays 0.
  - Release out_ready: all 8 vectors arrive in order and stall falls after the first pop.
- Overflow: same as backpressure but the bench ignores stall.
  - Expect overflow=1, only the first 4 vectors delivered, and done still pulsed after the FIFO empties.
- Edge cases:
  - start with tile_len=0: done pulses next cycle, busy stays 0, no out_valid.
  - start during COLLECT: ignored, and the current tile completes intact.
- Reset mid-tile: RESET=0 after 2 pushes.
  - Next cycle out_valid=0, busy=0, stall=0, with no done pulse.
  - A new start with M=1 returns vector {0,1,2,3}.
